fft_frame_ser: RTL and testbench
================================

# fft_frame_ser

Frame serializer downstream of the frequency-analysis top. It captures the 16 parallel FFT bins on each `fft_valid` pulse into a two-frame ping-pong buffer, then streams them one bin per cycle over a valid/ready interface toward the host or output port. Frame capture is decoupled from downstream backpressure. Frames arriving while both banks are occupied are dropped and counted.

## Interface
Parameters:
- `DROP_W`, 8: width of the saturating dropped-frame counter.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `fft_valid` in 1: one-cycle pulse; `fft_d0`..`fft_d15` are valid this cycle.
- `fft_d0`..`fft_d15` in 32 each: bin k; {re[31:16], im[15:0]}, both signed two's complement.
- `out_valid` out 1: `out_data`/`out_idx`/`out_last` hold a valid beat.
- `out_ready` in 1: downstream accepts the beat when `out_valid && out_ready`.
- `out_data` out 32: bin value, same format as input.
- `out_idx` out 4: bin index 0..15.
- `out_last` out 1: high on the bin-15 beat.
- `overflow` out 1: sticky; set on the first dropped frame, cleared only by reset.
- `drop_cnt` out `DROP_W`: number of dropped frames, saturating at all-ones.

## Operation
- **Storage:** two banks of 16×32 bits, plus write pointer `wp`, read pointer `rp` (1 bit each) and `fill` (0..2).
- **Capture:** on `fft_valid` with `fill < 2`, write all 16 bins into bank `wp`, toggle `wp`, and increment `fill`.
- **Drop:** on `fft_valid` with `fill == 2` (after accounting for a same-cycle release), discard the frame, set `overflow`, and increment `drop_cnt` unless it is saturated. No existing bank is modified.
- **Read FSM:**
  - IDLE: `out_valid` = 0. Go to STREAM when `fill > 0`, with `idx` = 0.
  - STREAM: present bank `rp`, bin `idx`. On a handshake, increment `idx`.
  - On a handshake with `idx == 15`: release bank `rp`, toggle `rp`, decrement `fill`. Go to IDLE if the resulting `fill` is 0; otherwise stay in STREAM with `idx` = 0 (no gap cycle).
- **Output stability:** the beat is registered. While `out_valid && !out_ready`, `out_data`, `out_idx` and `out_last` hold their values.
- **Simultaneous release and capture when `fill == 2`:** the release takes effect first, so the capture succeeds, `fill` stays 2, and nothing is dropped.
- **Capture and release in different banks:** no hazard, because the write bank is never `rp` while `fill > 0` and not full.
- **Reset during operation:** both banks are invalidated, `fill`/`wp`/`rp`/`idx` are zeroed, and any partial frame is discarded.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_idx` 0, `out_last` 0, `overflow` 0, `drop_cnt` 0. `mag` 0 when `FFT_SER_MAG_EN` is enabled.
- Latency: with `fft_valid` at cycle t and an idle block, the first beat (`out_idx` = 0) is valid at t+1.
- Throughput: one beat per cycle under continuous `out_ready`; a frame drains in 16 cycles.
- Capture costs no cycles on the read side; `fft_valid` never stalls.
- `overflow` and `drop_cnt` update in the cycle after the dropped `fft_valid`.

## Configuration
- Macro `FFT_SER_MAG_EN`.
- **Defined:** adds output `mag` [16:0] = |re| + |im|, with the 17-bit result computed without overflow. It is registered with the beat and follows the same hold rules as `out_data`.
- **Undefined:** the `mag` port and its logic are absent.
- All other behaviour is identical in both builds.

## Structure
- Shared package `fas_pkg` provides:
  - `NBIN` = 16
  - `BIN_W` = 32
  - `HALF_W` = 16
  - typedef `fft_bin_t` (packed re/im struct)
  - the read FSM state enum
- Sub-module `fft_ser_bank`: a two-bank register file with a 16-wide parallel write port and a single indexed read port. It is also reused by later host-interface blocks.

## Test plan
1. Single frame, bins 0x00010000·k+k, `out_ready` held 1. Expect:
   - 16 consecutive beats from t+1, `out_idx` 0..15, data matching input;
   - `out_last` only on beat 15;
   - IDLE afterwards.
2. Backpressure: `out_ready` low on beats 3 and 4 for 2 cycles each. Expect `out_data`/`out_idx` held during the stall, all 16 bins delivered in order, none skipped or duplicated.
3. `out_ready` held 0, then three frames spaced 16 cycles apart. Expect:
   - frame 3 dropped, `overflow` = 1, `drop_cnt` = 1;
   - after releasing ready, frames 1 and 2 delivered back-to-back with no gap between bin 15 and bin 0.
4. `fill` = 2 and `fft_valid` coinciding with the accepted bin-15 beat. Expect the capture to succeed, `drop_cnt` unchanged, and 3 frames total delivered.
5. `rst` asserted mid-frame (bin 7). Expect outputs zero immediately; after release, the next frame starts at `out_idx` 0 with no stale data.
6. (`FFT_SER_MAG_EN` build) bin {re = -300, im = 0x7FFF}. Expect `mag` = 33067. Bin {-32768, -32768}: expect `mag` = 65536.

Source files
------------

// File: rtl/fas_pkg.sv
// Shared definitions for the frequency-analysis output path.
//   NBIN / BIN_W / HALF_W : frame geometry (16 bins of 32-bit {re, im})
//   IDX_W                 : bin index width
//   fft_bin_t             : packed complex bin, re in [31:16], im in [15:0]
//   rd_state_t            : read-side FSM state of the frame serializer
//   bin_mag()             : |re| + |im| as an exact 17-bit value
package fas_pkg;

  localparam int NBIN   = 16;
  localparam int BIN_W  = 32;
  localparam int HALF_W = 16;
  localparam int IDX_W  = 4;

  typedef struct packed {
    logic signed [HALF_W-1:0] re;
    logic signed [HALF_W-1:0] im;
  } fft_bin_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_t;

  // Absolute values are formed one bit wider so that -32768 maps to +32768
  // and the sum cannot wrap.
  function automatic logic [HALF_W:0] bin_mag(input fft_bin_t b);
    logic [HALF_W:0] a_re;
    logic [HALF_W:0] a_im;
    a_re = b.re[HALF_W-1] ? (~{b.re[HALF_W-1], b.re} + 17'd1) : {1'b0, b.re};
    a_im = b.im[HALF_W-1] ? (~{b.im[HALF_W-1], b.im} + 17'd1) : {1'b0, b.im};
    return a_re + a_im;
  endfunction

endpackage

// File: rtl/fft_ser_bank.sv
// Two-bank frame register file.
//   clk      : clock
//   wr_en    : write all NBIN bins of bank wr_bank this cycle
//   wr_bank  : bank selected for the parallel write
//   wr_data  : NBIN bins, written together
//   rd_bank  : bank selected for the indexed read
//   rd_idx   : bin index for the read
//   rd_data  : combinational read data
// Contents are not reset; validity is tracked by the owner.
module fft_ser_bank
  import fas_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  fft_bin_t         wr_data [NBIN],
  input  logic             rd_bank,
  input  logic [IDX_W-1:0] rd_idx,
  output fft_bin_t         rd_data
);

  fft_bin_t mem [2][NBIN];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < NBIN; k++) begin
        mem[wr_bank][k] <= wr_data[k];
      end
    end
  end

  assign rd_data = mem[rd_bank][rd_idx];

endmodule

// File: rtl/fft_frame_ser.sv
// Frame serializer: captures 16 parallel FFT bins per fft_valid pulse into a
// ping-pong buffer and streams them one bin per cycle.
//   clk, rst              : clock, asynchronous active-low reset
//   fft_valid, fft_d0..15 : parallel frame input (never stalled)
//   out_valid/out_ready   : beat handshake; a beat transfers on the cycle both
//                           are high, and while out_valid && !out_ready the
//                           beat (data, idx, last, mag) is held unchanged
//   out_data/out_idx/out_last : registered beat
//   overflow, drop_cnt    : sticky drop flag, saturating drop counter
//   rd_state              : read FSM state (observability)
//   mag                   : |re|+|im| of the beat, only with FFT_SER_MAG_EN
module fft_frame_ser
  import fas_pkg::*;
#(
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fft_valid,
  input  logic [31:0]       fft_d0,
  input  logic [31:0]       fft_d1,
  input  logic [31:0]       fft_d2,
  input  logic [31:0]       fft_d3,
  input  logic [31:0]       fft_d4,
  input  logic [31:0]       fft_d5,
  input  logic [31:0]       fft_d6,
  input  logic [31:0]       fft_d7,
  input  logic [31:0]       fft_d8,
  input  logic [31:0]       fft_d9,
  input  logic [31:0]       fft_d10,
  input  logic [31:0]       fft_d11,
  input  logic [31:0]       fft_d12,
  input  logic [31:0]       fft_d13,
  input  logic [31:0]       fft_d14,
  input  logic [31:0]       fft_d15,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [3:0]        out_idx,
  output logic              out_last,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  output rd_state_t         rd_state
`ifdef FFT_SER_MAG_EN
  ,output logic [16:0]      mag
`endif
);

  rd_state_t         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rp_q, rp_d, wp_q, wp_d;
  logic [1:0]        fill_q, fill_d;
  logic [BIN_W-1:0]  data_q, data_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  fft_bin_t          wr_bins [NBIN];
  logic              rd_bank;
  logic [IDX_W-1:0]  rd_idx;
  fft_bin_t          rd_data;

  logic              hs, rel, cont, cap, drop;
  logic [1:0]        fill_rel;
  logic              rp_rel;

  assign wr_bins[0]  = fft_d0;
  assign wr_bins[1]  = fft_d1;
  assign wr_bins[2]  = fft_d2;
  assign wr_bins[3]  = fft_d3;
  assign wr_bins[4]  = fft_d4;
  assign wr_bins[5]  = fft_d5;
  assign wr_bins[6]  = fft_d6;
  assign wr_bins[7]  = fft_d7;
  assign wr_bins[8]  = fft_d8;
  assign wr_bins[9]  = fft_d9;
  assign wr_bins[10] = fft_d10;
  assign wr_bins[11] = fft_d11;
  assign wr_bins[12] = fft_d12;
  assign wr_bins[13] = fft_d13;
  assign wr_bins[14] = fft_d14;
  assign wr_bins[15] = fft_d15;

  fft_ser_bank u_bank (
    .clk     (clk),
    .wr_en   (cap),
    .wr_bank (wp_q),
    .wr_data (wr_bins),
    .rd_bank (rd_bank),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;

    hs   = (state_q == ST_STREAM) && out_ready;
    rel  = hs && (idx_q == 4'd15);
    cont = hs && !rel;

    // Release is applied before capture so a full buffer can accept a frame
    // in the same cycle its oldest frame finishes draining.
    fill_rel = fill_q - {1'b0, rel};
    rp_rel   = rp_q ^ rel;
    cap      = fft_valid && (fill_rel != 2'd2);
    drop     = fft_valid && (fill_rel == 2'd2);
    fill_d   = fill_rel + {1'b0, cap};
    wp_d     = wp_q ^ cap;
    rp_d     = rp_rel;

    rd_bank = cont ? rp_q : rp_rel;
    rd_idx  = cont ? (idx_q + 4'd1) : 4'd0;

    // A new beat is loaded whenever the output register is empty or drains.
    if ((state_q == ST_IDLE) || hs) begin
      if (cont || (fill_rel != 2'd0)) begin
        state_d = ST_STREAM;
        idx_d   = rd_idx;
        data_d  = rd_data;
      end else if (cap) begin
        // Empty buffer: bin 0 bypasses the bank so it is on the port one
        // cycle after fft_valid; the remaining bins come from bank wp == rp.
        state_d = ST_STREAM;
        idx_d   = 4'd0;
        data_d  = fft_d0;
      end else begin
        state_d = ST_IDLE;
      end
    end

    ovf_d  = ovf_q | drop;
    drop_d = (drop && (drop_q != '1)) ? (drop_q + 1'b1) : drop_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rp_q    <= 1'b0;
      wp_q    <= 1'b0;
      fill_q  <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid = (state_q == ST_STREAM);
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = (idx_q == 4'd15);
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;
  assign rd_state  = state_q;

`ifdef FFT_SER_MAG_EN
  logic [16:0] mag_q;

  // Tracks data_d every cycle, so it holds exactly when the beat holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_q <= '0;
    end else begin
      mag_q <= bin_mag(data_d);
    end
  end

  assign mag = mag_q;
`endif

endmodule

// File: tb/tb_fft_frame_ser.sv
// Bench for fft_frame_ser. The reference model is a queue of expected
// {idx, data} beats plus a count of frames held; frames are accepted while
// fewer than two are held after any same-cycle completion.
module tb_fft_frame_ser;
  import fas_pkg::*;

  localparam int DROP_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              fft_valid;
  logic [31:0]       d [16];
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [3:0]        out_idx;
  logic              out_last;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;
  rd_state_t         rd_state;
`ifdef FFT_SER_MAG_EN
  logic [16:0]       mag;
`endif

  fft_frame_ser #(.DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
    .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
    .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .overflow(overflow),
    .drop_cnt(drop_cnt), .rd_state(rd_state)
`ifdef FFT_SER_MAG_EN
    , .mag(mag)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [35:0] exp_q[$];
  int          m_held;
  int          m_drops;
  logic        m_ovf;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int absv(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_held  = 0;
    m_drops = 0;
    m_ovf   = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // One clock: compare outputs at the falling edge, advance the model with the
  // inputs that the next rising edge will see, then return 1 ns after it.
  task automatic step();
    logic        exp_v;
    logic [35:0] head;
    int          re, im;
    @(negedge clk);
    exp_v = (exp_q.size() > 0);
    check("out_valid", out_valid, exp_v);
    check("streaming", rd_state == ST_STREAM, exp_v);
    check("overflow", overflow, m_ovf);
    check("drop_cnt", drop_cnt, m_drops);
    head = '0;
    if (exp_v) begin
      head = exp_q[0];
      check("out_idx", out_idx, head[35:32]);
      check("out_data", out_data, head[31:0]);
      check("out_last", out_last, head[35:32] == 4'd15);
`ifdef FFT_SER_MAG_EN
      re = $signed(head[31:16]);
      im = $signed(head[15:0]);
      check("mag", mag, absv(re) + absv(im));
`endif
    end
    if (exp_v && out_ready) begin
      void'(exp_q.pop_front());
      if (head[35:32] == 4'd15) m_held--;
    end
    if (fft_valid) begin
      if (m_held < 2) begin
        m_held++;
        for (int k = 0; k < 16; k++) exp_q.push_back({4'(k), d[k]});
      end else begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_random();
    for (int k = 0; k < 16; k++) d[k] = $urandom;
  endtask

  task automatic send_frame();
    fft_valid = 1'b1;
    step();
    fft_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && b > 0) begin
      step();
      b--;
    end
    check("drain_timeout", exp_q.size(), 0);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
`ifdef FFT_SER_MAG_EN
    check("rst_mag", mag, 0);
`endif
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b;
    int stalls [16];
    rst       = 1'b0;
    fft_valid = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) d[k] = '0;
    model_clear();
    #2;
    do_reset();
    idle_cycles(2);

    // Single frame, continuous ready.
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) d[k] = 32'h0001_0000 * k + k;
    send_frame();
    check("t1_first_beat_idx", out_idx, 0);
    check("t1_first_beat_valid", out_valid, 1);
    drain(40);
    check("t1_idle_after", rd_state == ST_IDLE, 1);

    // Backpressure on beats 3 and 4, two cycles each.
    load_random();
    send_frame();
    for (int k = 0; k < 16; k++) stalls[k] = 0;
    b = 60;
    while (exp_q.size() > 0 && b > 0) begin
      if ((exp_q[0][35:32] == 4'd3 || exp_q[0][35:32] == 4'd4) &&
          stalls[exp_q[0][35:32]] < 2) begin
        out_ready = 1'b0;
        stalls[exp_q[0][35:32]]++;
      end else begin
        out_ready = 1'b1;
      end
      step();
      b--;
    end
    check("t2_drain_timeout", exp_q.size(), 0);
    step();

    // Ready low, three frames 16 cycles apart; the third is dropped.
    out_ready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      load_random();
      send_frame();
      idle_cycles(15);
    end
    check("t3_overflow", overflow, 1);
    check("t3_drop_cnt", drop_cnt, 1);
    drain(60);

    // Full buffer, fft_valid on the accepted bin-15 beat of the oldest frame.
    out_ready = 1'b0;
    load_random();
    send_frame();
    load_random();
    send_frame();
    out_ready = 1'b1;
    b = 40;
    while (!(exp_q.size() == 17) && b > 0) begin
      step();
      b--;
    end
    check("t4_reach_last_timeout", exp_q.size(), 17);
    load_random();
    send_frame();
    check("t4_drop_cnt_unchanged", drop_cnt, 1);
    check("t4_frames_pending", exp_q.size(), 32);
    drain(80);

`ifdef FFT_SER_MAG_EN
    // Magnitude corner values.
    out_ready = 1'b1;
    load_random();
    d[0] = {16'hFED4, 16'h7FFF};
    d[1] = {16'h8000, 16'h8000};
    send_frame();
    check("t6_mag_a", mag, 17'd33067);
    step();
    check("t6_mag_b", mag, 17'd65536);
    drain(40);
`endif

    // Reset while bin 7 is on the port.
    out_ready = 1'b1;
    load_random();
    send_frame();
    b = 20;
    while (!(exp_q.size() > 0 && exp_q[0][35:32] == 4'd7) && b > 0) begin
      step();
      b--;
    end
    check("t5_reach_bin7", out_idx, 7);
    do_reset();
    idle_cycles(2);
    load_random();
    send_frame();
    check("t5_restart_idx", out_idx, 0);
    check("t5_restart_data", out_data, d[0]);
    drain(40);

    // Drop counter saturation.
    out_ready = 1'b0;
    load_random();
    send_frame();
    send_frame();
    fft_valid = 1'b1;
    idle_cycles(260);
    fft_valid = 1'b0;
    step();
    check("sat_drop_cnt", drop_cnt, 255);
    check("sat_overflow", overflow, 1);
    drain(60);
    do_reset();
    idle_cycles(2);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      fft_valid = ($urandom_range(0, 11) == 0);
      if (fft_valid) load_random();
      step();
    end
    fft_valid = 1'b0;
    drain(80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
